// File: rtl/traffic_light_sequencer.sv
// rtl/traffic_light_sequencer.sv - N-way round-robin intersection light sequencer
// Optional night flash mode is built only when TLC_FLASH_EN is defined.
module traffic_light_sequencer #(
  parameter int N_WAYS     = 4,
  parameter int G_MIN      = 80,
  parameter int Y_TIME     = 20,
  parameter int R_TIME     = 4,
  parameter int FLASH_HALF = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_WAYS-1:0]     has_car,
  input  logic                  flash_mode,
  output logic [3*N_WAYS-1:0]   lights,
  output logic [2:0]            cur_way
);

  typedef enum logic [1:0] {
    S_GREEN   = 2'd0,
    S_YELLOW  = 2'd1,
    S_ALL_RED = 2'd2,
    S_FLASH   = 2'd3
  } state_t;

  localparam logic [15:0] G_LAST = 16'(G_MIN - 1);
  localparam logic [15:0] Y_LAST = 16'(Y_TIME - 1);
  localparam logic [15:0] R_LAST = 16'(R_TIME - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  cur_way_q, cur_way_d;
  logic [2:0]  target_q, target_d;
  logic [3:0]  next_pick;

`ifdef TLC_FLASH_EN
  localparam logic [15:0] F_LAST = 16'(FLASH_HALF - 1);
  logic phase_q, phase_d;
`else
  logic unused_flash;
  assign unused_flash = flash_mode | (FLASH_HALF == 0);
`endif

  // Bit 3 flags a hit; the scan runs farthest-first so the nearest waiting
  // approach in rotation order is the last one written and therefore wins.
  function automatic logic [3:0] next_waiting(input logic [N_WAYS-1:0] cars,
                                               input logic [2:0]        cur);
    logic [2*N_WAYS-1:0] dbl;
    logic [N_WAYS-1:0]   rot;
    logic [3:0]          r;
    dbl = {cars, cars};
    rot = N_WAYS'(dbl >> cur);
    r   = 4'd0;
    for (int k = N_WAYS - 1; k >= 1; k--) begin
      if (rot[k]) r = {1'b1, 3'((int'(cur) + k) % N_WAYS)};
    end
    return r;
  endfunction

  assign next_pick = next_waiting(has_car, cur_way_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    cur_way_d = cur_way_q;
    target_d  = target_q;
`ifdef TLC_FLASH_EN
    phase_d   = phase_q;
`endif
    case (state_q)
      S_GREEN: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (cnt_q >= G_LAST && next_pick[3]) begin
          state_d  = S_YELLOW;
          target_d = next_pick[2:0];
        end
      end
      S_YELLOW: begin
        if (cnt_q >= Y_LAST) begin
          state_d   = S_ALL_RED;
          cur_way_d = target_q;
        end
      end
      S_ALL_RED: begin
        if (cnt_q >= R_LAST) state_d = S_GREEN;
      end
`ifdef TLC_FLASH_EN
      S_FLASH: begin
        if (cnt_q >= F_LAST) begin
          cnt_d   = 16'd0;
          phase_d = ~phase_q;
        end
        if (!flash_mode) begin
          state_d   = S_ALL_RED;
          cur_way_d = 3'd0;
          target_d  = 3'd0;
        end
      end
`endif
      default: state_d = S_ALL_RED;
    endcase
`ifdef TLC_FLASH_EN
    if (flash_mode && state_q != S_FLASH) begin
      state_d   = S_FLASH;
      cur_way_d = 3'd0;
      phase_d   = 1'b0;
    end
`endif
    if (state_d != state_q) cnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_GREEN;
      cnt_q     <= 16'd0;
      cur_way_q <= 3'd0;
      target_q  <= 3'd0;
`ifdef TLC_FLASH_EN
      phase_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_way_q <= cur_way_d;
      target_q  <= target_d;
`ifdef TLC_FLASH_EN
      phase_q   <= phase_d;
`endif
    end
  end

  always_comb begin
    logic [2:0] lamp;
    lights = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      lamp = 3'b001;
      case (state_q)
        S_GREEN:  if (cur_way_q == 3'(i)) lamp = 3'b100;
        S_YELLOW: if (cur_way_q == 3'(i)) lamp = 3'b010;
`ifdef TLC_FLASH_EN
        S_FLASH:  lamp = phase_q ? 3'b000 : 3'b010;
`endif
        default:  lamp = 3'b001;
      endcase
      lights[3*i +: 3] = lamp;
    end
  end

  assign cur_way = cur_way_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb/tb_traffic_light_sequencer.sv - directed self-checking bench for traffic_light_sequencer
// Flash scenario is exercised when TLC_FLASH_EN is defined.
module tb_traffic_light_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  has_car;
  logic        flash_mode;
  logic [11:0] lights;
  logic [2:0]  cur_way;

  int total = 0;
  int bad   = 0;

  localparam int M_GREEN = 0, M_YELLOW = 1, M_RED = 2, M_FON = 3, M_FOFF = 4;

  traffic_light_sequencer #(
    .N_WAYS(4), .G_MIN(8), .Y_TIME(3), .R_TIME(2), .FLASH_HALF(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .has_car(has_car), .flash_mode(flash_mode),
    .lights(lights), .cur_way(cur_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] lamps(input int mode, input int way);
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      case (mode)
        M_GREEN:  v[3*i +: 3] = (i == way) ? 3'b100 : 3'b001;
        M_YELLOW: v[3*i +: 3] = (i == way) ? 3'b010 : 3'b001;
        M_RED:    v[3*i +: 3] = 3'b001;
        M_FON:    v[3*i +: 3] = 3'b010;
        default:  v[3*i +: 3] = 3'b000;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int mode, input int way, input int cw);
    check({tag, "_lights"}, lights, lamps(mode, way));
    check({tag, "_cur_way"}, {9'd0, cur_way}, 12'(cw));
  endtask

  // Leaves the bench in cycle 0: the first cycle after the reset edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts on a green cycle of from_way, ends on the first green cycle of to_way.
  task automatic expect_service(input string tag, input int from_way, input int to_way,
                                input int green_len);
    for (int i = 0; i < green_len; i++) begin
      check_state({tag, "_green"}, M_GREEN, from_way, from_way);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check_state({tag, "_yellow"}, M_YELLOW, from_way, from_way);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      check_state({tag, "_allred"}, M_RED, 0, to_way);
      @(negedge clk);
    end
    check_state({tag, "_next_green"}, M_GREEN, to_way, to_way);
  endtask

  initial begin
    rst_n      = 1'b0;
    has_car    = 4'b0000;
    flash_mode = 1'b0;

    // Idle: green on 0 holds for 50 cycles
    do_reset();
    for (int c = 0; c < 50; c++) begin
      check_state("idle", M_GREEN, 0, 0);
      @(negedge clk);
    end

    // Car on 2 from reset: 8 green, 3 yellow, 2 all-red, green 2 on cycle 13
    has_car = 4'b0100;
    do_reset();
    expect_service("to2", 0, 2, 8);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_state("own_car_hold", M_GREEN, 2, 2);
    end

    // Approach 1 green with cars on 1 and 3: target is 3, then wraps to 1
    has_car = 4'b0010;
    do_reset();
    expect_service("to1", 0, 1, 8);
    has_car = 4'b1010;
    expect_service("skip_own", 1, 3, 8);
    expect_service("wrap", 3, 1, 8);

    // Late arrival on 3 at cycle 20: yellow on cycle 21
    has_car = 4'b0000;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      check_state("late_wait", M_GREEN, 0, 0);
      @(negedge clk);
    end
    has_car = 4'b1000;
    expect_service("late", 0, 3, 1);

    // Reset during yellow on 2 restarts green on 0 with a fresh counter
    has_car = 4'b0100;
    do_reset();
    expect_service("pre", 0, 2, 8);
    has_car = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      check_state("mid_green", M_GREEN, 2, 2);
      @(negedge clk);
    end
    check_state("mid_yellow", M_YELLOW, 2, 2);
    @(negedge clk);
    check_state("mid_yellow2", M_YELLOW, 2, 2);
    has_car = 4'b0010;
    do_reset();
    expect_service("after_rst", 0, 1, 8);

`ifdef TLC_FLASH_EN
    has_car = 4'b0000;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      check_state("pre_flash", M_GREEN, 0, 0);
      @(negedge clk);
    end
    flash_mode = 1'b1;
    check_state("pre_flash_last", M_GREEN, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      check_state("flash", ((i / 4) % 2 == 0) ? M_FON : M_FOFF, 0, 0);
      @(negedge clk);
    end
    flash_mode = 1'b0;
    check_state("flash_last", M_FON, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_state("flash_allred", M_RED, 0, 0);
      @(negedge clk);
    end
    check_state("flash_exit_green", M_GREEN, 0, 0);
`else
    has_car = 4'b0000;
    do_reset();
    flash_mode = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_state("flash_ignored", M_GREEN, 0, 0);
    end
    flash_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
